// File: rtl/parity_frame.sv
// rtl/parity_frame.sv - frame parity checker: XOR-accumulates beats, reports parity/error/beat count per frame.
// Optional error counter enabled by defining PARITY_FRAME_ERR_CNT_EN.
module parity_frame #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             in_par,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_par,
  output logic             out_err,
  output logic [CNT_W-1:0] out_beats,
  output logic [15:0]      err_cnt
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_e;

  state_e             state_q, state_d;
  logic               acc_q, acc_d;
  logic               mode_q, mode_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               out_par_q, out_par_d;
  logic               out_err_q, out_err_d;

  logic               accept;
  logic               first_beat;
  logic               acc_nxt;
  logic               mode_eff;
  logic               par_nxt;
  logic [CNT_W-1:0]   cnt_base;

  assign in_ready  = (state_q != DONE);
  assign out_valid = (state_q == DONE);
  assign out_par   = out_par_q;
  assign out_err   = out_err_q;
  assign out_beats = cnt_q;

  assign accept     = in_valid && in_ready;
  assign first_beat = (state_q == IDLE);

  // The first beat of a frame starts from a clean accumulator and latches mode.
  always_comb begin
    acc_nxt  = (first_beat ? 1'b0 : acc_q) ^ (^in_data);
    mode_eff = first_beat ? mode : mode_q;
    par_nxt  = acc_nxt ^ mode_eff;
    cnt_base = first_beat ? '0 : cnt_q;
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    out_par_d = out_par_q;
    out_err_d = out_err_q;
    case (state_q)
      IDLE, ACC: begin
        if (accept) begin
          acc_d  = acc_nxt;
          mode_d = mode_eff;
          cnt_d  = (cnt_base == {CNT_W{1'b1}}) ? cnt_base : cnt_base + CNT_W'(1);
          if (in_last) begin
            state_d   = DONE;
            out_par_d = par_nxt;
            out_err_d = par_nxt ^ in_par;
          end else begin
            state_d = ACC;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          acc_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= 1'b0;
      mode_q    <= 1'b0;
      cnt_q     <= '0;
      out_par_q <= 1'b0;
      out_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mode_q    <= mode_d;
      cnt_q     <= cnt_d;
      out_par_q <= out_par_d;
      out_err_q <= out_err_d;
    end
  end

`ifdef PARITY_FRAME_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (out_valid && out_ready && out_err_q && (err_cnt_q != 16'hFFFF))
      err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= 16'd0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_parity_frame.sv
// tb/tb_parity_frame.sv - directed self-checking bench for parity_frame (default and CNT_W=2 instances).
module tb_parity_frame;

  logic        clk;
  logic        rst_n;
  logic        mode;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_par;
  logic        out_ready;

  logic        in_ready, out_valid, out_par, out_err;
  logic [7:0]  out_beats;
  logic [15:0] err_cnt;

  logic        in_ready2, out_valid2, out_par2, out_err2;
  logic [1:0]  out_beats2;
  logic [15:0] err_cnt2;

  int tests_run = 0;
  int tests_failed = 0;

`ifdef PARITY_FRAME_ERR_CNT_EN
  localparam logic [15:0] ERR_INC = 16'd1;
`else
  localparam logic [15:0] ERR_INC = 16'd0;
`endif

  parity_frame #(.WIDTH(8), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_par(in_par),
    .out_valid(out_valid), .out_ready(out_ready), .out_par(out_par),
    .out_err(out_err), .out_beats(out_beats), .err_cnt(err_cnt)
  );

  parity_frame #(.WIDTH(8), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
    .in_last(in_last), .in_par(in_par),
    .out_valid(out_valid2), .out_ready(out_ready), .out_par(out_par2),
    .out_err(out_err2), .out_beats(out_beats2), .err_cnt(err_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic last, input logic par, input logic md);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    in_par   = par;
    mode     = md;
    check("in_ready_before_beat", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_par   = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic par, input logic err, input logic [7:0] beats);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
    check({tag, "_par"},   {31'd0, out_par},  {31'd0, par});
    check({tag, "_err"},   {31'd0, out_err},  {31'd0, err});
    check({tag, "_beats"}, {24'd0, out_beats}, {24'd0, beats});
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_idle_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_idle_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; mode = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    in_last = 1'b0; in_par = 1'b0; out_ready = 1'b0;
    repeat (2) step();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_par",   {31'd0, out_par},   32'd0);
    check("rst_out_err",   {31'd0, out_err},   32'd0);
    check("rst_out_beats", {24'd0, out_beats}, 32'd0);
    check("rst_err_cnt",   {16'd0, err_cnt},   32'd0);
    rst_n = 1'b1;
    step();
    check("post_rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);

    // Single beat, even parity, matching in_par.
    send_beat(8'h07, 1'b1, 1'b1, 1'b0);
    check_result("t1", 1'b1, 1'b0, 8'd1);
    handshake("t1");
    check("t1_err_cnt", {16'd0, err_cnt}, 32'd0);

    // Same beat, odd parity: error reported and counted on handshake.
    send_beat(8'h07, 1'b1, 1'b1, 1'b1);
    check_result("t2", 1'b0, 1'b1, 8'd1);
    check("t2_err_cnt_pre", {16'd0, err_cnt}, 32'd0);
    handshake("t2");
    check("t2_err_cnt_post", {16'd0, err_cnt}, {16'd0, ERR_INC});

    // Three-beat frame with mode toggled mid-frame, then a 5-cycle stall in DONE.
    send_beat(8'h01, 1'b0, 1'b0, 1'b0);
    check("t3_mid_valid", {31'd0, out_valid}, 32'd0);
    send_beat(8'h03, 1'b0, 1'b0, 1'b1);
    send_beat(8'h80, 1'b1, 1'b0, 1'b0);
    check_result("t3", 1'b0, 1'b0, 8'd3);
    for (int i = 0; i < 5; i++) begin
      step();
      check_result("t3_stall", 1'b0, 1'b0, 8'd3);
    end
    handshake("t3");
    check("t3_err_cnt", {16'd0, err_cnt}, {16'd0, ERR_INC});

    // Six-beat frame: saturation in the narrow counter.
    for (int i = 0; i < 6; i++) send_beat(8'h01, (i == 5), 1'b0, 1'b0);
    check_result("t4", 1'b0, 1'b0, 8'd6);
    check("t4_beats_sat", {30'd0, out_beats2}, 32'd3);
    check("t4_valid2",    {31'd0, out_valid2}, 32'd1);
    handshake("t4");

    // Reset after two beats discards the frame and clears the accumulator.
    send_beat(8'h01, 1'b0, 1'b0, 1'b0);
    send_beat(8'h00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    step();
    check("t5_rst_err_cnt", {16'd0, err_cnt}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5_no_valid", {31'd0, out_valid}, 32'd0);
    end
    send_beat(8'h00, 1'b1, 1'b0, 1'b0);
    check_result("t5", 1'b0, 1'b0, 8'd1);
    handshake("t5");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
